ibex_mem_xbar: RTL and testbench

- Two-master to one-slave memory interconnect between the Ibex instruction/data bus ports and the single-port SRAM.
- Arbitrates instruction and data requests and decodes the SRAM address window.
- Returns unmapped accesses as bus errors.
- Routes each one-cycle-latency SRAM response back to the port that issued it; back-to-back pipelined transfers are supported.

---
 rtl/ibex_mem_xbar_pkg.sv | 38 +++
 rtl/xbar_rr_arb.sv | 55 +++++
 rtl/ibex_mem_xbar.sv | 145 ++++++++++++++
 tb/tb_ibex_mem_xbar.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_mem_xbar_pkg.sv
// ibex_mem_xbar_pkg
//   Types and a decode helper shared by the Ibex two-master memory crossbar
//   and its arbiter.
//   - xbar_port_e  : identifies the instruction or data master
//   - resp_state_e : registered response stage of the crossbar
//   - req_t        : request fields that are forwarded to the SRAM
//   - addr_in_range: checks an address against a size-aligned window
package ibex_mem_xbar_pkg;

  typedef enum logic {
    PortInstr,
    PortData
  } xbar_port_e;

  typedef enum logic [2:0] {
    RespIdle,
    RespInstr,
    RespData,
    ErrInstr,
    ErrData
  } resp_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // The window is a power-of-two size aligned to its base, so an address
  // belongs to it when the bits above the offset match the base exactly.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] mask,
                                         input logic [31:0] base);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/xbar_rr_arb.sv
// xbar_rr_arb
//   Two-way combinational arbiter between the instruction and data masters.
//   A lone requester always wins. On contention the port that did not win
//   the previous contention wins (RoundRobin=1), or instruction always wins
//   (RoundRobin=0). No grant is given while rst_i is high.
//   Ports:
//     clk_i, rst_i          clock, synchronous active-high reset
//     req_instr, req_data   requests from the two masters
//     gnt_instr, gnt_data   one-hot (or zero) grants, same cycle as request
module xbar_rr_arb
  import ibex_mem_xbar_pkg::*;
#(
  parameter bit RoundRobin = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_instr,
  input  logic req_data,
  output logic gnt_instr,
  output logic gnt_data
);

  xbar_port_e last_winner_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case can leave it unassigned and infer a latch.
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (!rst_i) begin
      if (req_instr && req_data) begin
        if (RoundRobin && (last_winner_q == PortInstr)) begin
          gnt_data = 1'b1;
        end else begin
          gnt_instr = 1'b1;
        end
      end else begin
        gnt_instr = req_instr;
        gnt_data  = req_data;
      end
    end
  end

  // Resetting to PortData hands the first contention to the instruction port.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_winner_q <= PortData;
    end else if (req_instr && req_data) begin
      last_winner_q <= gnt_data ? PortData : PortInstr;
    end
  end

endmodule

// File: rtl/ibex_mem_xbar.sv
// ibex_mem_xbar
//   Connects the Ibex instruction and data OBI ports to one single-port SRAM
//   with one cycle of read latency. The winning request is granted in the
//   same cycle; if it hits the SRAM window it is forwarded on mem_*,
//   otherwise it is absorbed and answered with an error. The response stage
//   routes the next-cycle response to the port that issued the request, so
//   one transfer per cycle is sustained.
//   Ports:
//     clk_i, rst_i                  clock, synchronous active-high reset
//     instr_*                       Ibex instruction fetch port (read only)
//     data_*                        Ibex load/store port
//     mem_req_o .. mem_wdata_o      SRAM request side
//     mem_rvalid_i, mem_rdata_i     SRAM response, one cycle after mem_req_o
module ibex_mem_xbar
  import ibex_mem_xbar_pkg::*;
#(
  parameter int unsigned MemSize    = 65536,
  parameter logic [31:0] MemStart   = 32'h0000_0000,
  parameter bit          RoundRobin = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] AddrMask = ~(32'(MemSize) - 32'd1);

  logic        gnt_instr;
  logic        gnt_data;
  logic        win_valid;
  logic        win_in_range;
  req_t        win_req;
  resp_state_e state_q;
  resp_state_e state_d;

  xbar_rr_arb #(
    .RoundRobin(RoundRobin)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_instr(instr_req_i),
    .req_data (data_req_i),
    .gnt_instr(gnt_instr),
    .gnt_data (gnt_data)
  );

  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  // Fetches are presented to the SRAM as full-word reads.
  always_comb begin
    win_req = '0;
    if (gnt_instr) begin
      win_req.be   = 4'hF;
      win_req.addr = instr_addr_i;
    end else if (gnt_data) begin
      win_req = '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};
    end
  end

  assign win_valid    = gnt_instr | gnt_data;
  assign win_in_range = addr_in_range(win_req.addr, AddrMask, MemStart);

  // An unmapped winner is still granted but never reaches the SRAM.
  assign mem_req_o   = win_valid & win_in_range;
  assign mem_we_o    = mem_req_o & win_req.we;
  assign mem_be_o    = mem_req_o ? win_req.be    : 4'h0;
  assign mem_addr_o  = mem_req_o ? win_req.addr  : 32'h0;
  assign mem_wdata_o = mem_req_o ? win_req.wdata : 32'h0;

  always_comb begin
    state_d = RespIdle;
    if (gnt_instr) begin
      state_d = win_in_range ? RespInstr : ErrInstr;
    end else if (gnt_data) begin
      state_d = win_in_range ? RespData : ErrData;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RespIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Responses come from the state register; mem_rvalid_i only cross-checks it.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = 32'h0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = 32'h0;
    data_err_o     = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        RespInstr: begin
          instr_rvalid_o = 1'b1;
          instr_rdata_o  = mem_rdata_i;
        end
        ErrInstr: begin
          instr_rvalid_o = 1'b1;
          instr_err_o    = 1'b1;
        end
        RespData: begin
          data_rvalid_o = 1'b1;
          data_rdata_o  = mem_rdata_i;
        end
        ErrData: begin
          data_rvalid_o = 1'b1;
          data_err_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  mem_rvalid_matches_state: assert property (
    @(posedge clk_i) disable iff (rst_i)
    mem_rvalid_i == ((state_q == RespInstr) || (state_q == RespData))
  );

endmodule

// File: tb/tb_ibex_mem_xbar.sv
// tb_ibex_mem_xbar
//   Drives two crossbar instances from the same master stimulus:
//     dut0: 64 KiB at 0x0, round-robin arbitration
//     dut1: 4 KiB at 0x0001_0000, fixed instruction priority
//   Each instance has its own SRAM stand-in. A transaction-level model per
//   instance predicts grants, the forwarded SRAM request and the response
//   one cycle later; directed sequences come first, then random traffic.
module tb_ibex_mem_xbar;

  localparam int unsigned SIZE0  = 65536;
  localparam logic [31:0] START0 = 32'h0000_0000;
  localparam int unsigned SIZE1  = 4096;
  localparam logic [31:0] START1 = 32'h0001_0000;

  typedef struct packed {
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } obs_t;

  // Outstanding response predicted from the previous cycle's grant.
  typedef struct {
    bit          last_data;
    bit          pend;
    bit          pend_data;
    bit          pend_err;
    logic [31:0] pend_addr;
  } mdl_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;

  obs_t obs [2];
  mdl_t mdl [2];
  mdl_t nxt [2];
  bit   g0_instr;
  bit   g0_data;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk_i = ~clk_i;

  // Read-only SRAM contents: one preloaded word, the rest a fixed scramble.
  function automatic logic [31:0] sram_word(input logic [31:0] addr);
    if (addr[31:2] == 30'h20) return 32'hDEAD_BEEF;
    return {addr[15:0] ^ 16'h5A5A, addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        i_gnt, i_rv, i_err, d_gnt, d_rv, d_err, m_req, m_we;
    logic [31:0] i_rd, d_rd, m_addr, m_wd;
    logic [3:0]  m_be;
    logic        sram_rv;
    logic [31:0] sram_rd;

    ibex_mem_xbar #(
      .MemSize   (g == 0 ? SIZE0 : SIZE1),
      .MemStart  (g == 0 ? START0 : START1),
      .RoundRobin(g == 0)
    ) u_dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .instr_req_i   (instr_req_i),
      .instr_addr_i  (instr_addr_i),
      .instr_gnt_o   (i_gnt),
      .instr_rvalid_o(i_rv),
      .instr_rdata_o (i_rd),
      .instr_err_o   (i_err),
      .data_req_i    (data_req_i),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_addr_i   (data_addr_i),
      .data_wdata_i  (data_wdata_i),
      .data_gnt_o    (d_gnt),
      .data_rvalid_o (d_rv),
      .data_rdata_o  (d_rd),
      .data_err_o    (d_err),
      .mem_req_o     (m_req),
      .mem_we_o      (m_we),
      .mem_be_o      (m_be),
      .mem_addr_o    (m_addr),
      .mem_wdata_o   (m_wd),
      .mem_rvalid_i  (sram_rv),
      .mem_rdata_i   (sram_rd)
    );

    // Junk on the read bus when idle exposes any leak of unqualified data.
    always @(posedge clk_i) begin
      if (rst_i) begin
        sram_rv <= 1'b0;
        sram_rd <= $urandom;
      end else begin
        sram_rv <= m_req;
        sram_rd <= m_req ? sram_word(m_addr) : $urandom;
      end
    end

    assign obs[g] = {i_gnt, i_rv, i_rd, i_err, d_gnt, d_rv, d_rd, d_err,
                     m_req, m_we, m_be, m_addr, m_wd};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [63:0] win_lo(input int k);
    return 64'(k == 0 ? START0 : START1);
  endfunction

  function automatic logic [63:0] win_hi(input int k);
    return win_lo(k) + 64'(k == 0 ? SIZE0 : SIZE1);
  endfunction

  task automatic model_check(input int k);
    obs_t        o = obs[k];
    bit          rr = (k == 0);
    bit          gi = 1'b0;
    bit          gd = 1'b0;
    bit          in_r;
    bit          ri;
    bit          rd;
    logic [31:0] a;
    logic [31:0] exp_rd;
    string       p = $sformatf("dut%0d.", k);

    if (rst_i) begin
      check({p, "rst_instr_gnt"},    32'(o.instr_gnt),    32'h0);
      check({p, "rst_data_gnt"},     32'(o.data_gnt),     32'h0);
      check({p, "rst_instr_rvalid"}, 32'(o.instr_rvalid), 32'h0);
      check({p, "rst_data_rvalid"},  32'(o.data_rvalid),  32'h0);
      check({p, "rst_mem_req"},      32'(o.mem_req),      32'h0);
      nxt[k] = '{last_data: 1'b1, pend: 1'b0, pend_data: 1'b0, pend_err: 1'b0, pend_addr: 32'h0};
      if (k == 0) begin
        g0_instr = 1'b0;
        g0_data  = 1'b0;
      end
      return;
    end

    if (instr_req_i && data_req_i) begin
      if (rr && !mdl[k].last_data) gd = 1'b1;
      else gi = 1'b1;
    end else begin
      gi = instr_req_i;
      gd = data_req_i;
    end
    a    = gi ? instr_addr_i : data_addr_i;
    in_r = ({32'h0, a} >= win_lo(k)) && ({32'h0, a} < win_hi(k));

    check({p, "instr_gnt"}, 32'(o.instr_gnt), 32'(gi));
    check({p, "data_gnt"},  32'(o.data_gnt),  32'(gd));
    check({p, "mem_req"},   32'(o.mem_req),   32'((gi || gd) && in_r));
    if ((gi || gd) && in_r) begin
      check({p, "mem_addr"},  o.mem_addr,         a);
      check({p, "mem_we"},    32'(o.mem_we),      32'(gd && data_we_i));
      check({p, "mem_be"},    32'(o.mem_be),      32'(gi ? 4'hF : data_be_i));
      check({p, "mem_wdata"}, o.mem_wdata,        gi ? 32'h0 : data_wdata_i);
    end
    if (!gi && !gd) begin
      check({p, "mem_idle"}, o.mem_addr | o.mem_wdata | 32'({o.mem_we, o.mem_be}), 32'h0);
    end

    ri     = mdl[k].pend && !mdl[k].pend_data;
    rd     = mdl[k].pend && mdl[k].pend_data;
    exp_rd = mdl[k].pend_err ? 32'h0 : sram_word(mdl[k].pend_addr);
    check({p, "instr_rvalid"}, 32'(o.instr_rvalid), 32'(ri));
    check({p, "instr_err"},    32'(o.instr_err),    32'(ri && mdl[k].pend_err));
    check({p, "instr_rdata"},  o.instr_rdata,       ri ? exp_rd : 32'h0);
    check({p, "data_rvalid"},  32'(o.data_rvalid),  32'(rd));
    check({p, "data_err"},     32'(o.data_err),     32'(rd && mdl[k].pend_err));
    check({p, "data_rdata"},   o.data_rdata,        rd ? exp_rd : 32'h0);

    nxt[k].last_data = (instr_req_i && data_req_i) ? gd : mdl[k].last_data;
    nxt[k].pend      = gi || gd;
    nxt[k].pend_data = gd;
    nxt[k].pend_err  = !in_r;
    nxt[k].pend_addr = a;
    if (k == 0) begin
      g0_instr = gi;
      g0_data  = gd;
    end
  endtask

  // Inputs are already driven 1 time unit after a rising edge; check just
  // before the falling edge, then advance to the next drive point.
  task automatic step();
    #3;
    for (int k = 0; k < 2; k++) model_check(k);
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 2; k++) mdl[k] = nxt[k];
  endtask

  task automatic set_i(input bit req, input logic [31:0] addr);
    instr_req_i  = req;
    instr_addr_i = addr;
  endtask

  task automatic set_d(input bit req, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    data_req_i   = req;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
  endtask

  task automatic idle();
    set_i(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 4))
      0:       return {16'h0, r[15:2], 2'b00};
      1:       return 32'h0001_0000 + {19'h0, r[12:2], 2'b00};
      2:       return {r[31:2], 2'b00};
      3: begin
        case ($urandom_range(0, 4))
          0:       return 32'h0000_0000;
          1:       return 32'h0000_FFFC;
          2:       return 32'h0001_0000;
          3:       return 32'h0001_0FFC;
          default: return 32'h0001_1000;
        endcase
      end
      default: return {16'h0, r[15:2], 2'b00};
    endcase
  endfunction

  // A master that requested and lost keeps its request unchanged.
  task automatic rand_cycle();
    if (!(instr_req_i && !g0_instr)) begin
      set_i($urandom_range(0, 3) != 0, rand_addr());
    end
    if (!(data_req_i && !g0_data)) begin
      set_d($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
    end
    step();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mdl[k] = '{last_data: 1'b1, pend: 1'b0, pend_data: 1'b0, pend_err: 1'b0, pend_addr: 32'h0};
    end
    g0_instr = 1'b0;
    g0_data  = 1'b0;
    idle();
    #1;
    step();
    do_reset();

    // Single instruction fetch of the preloaded word.
    set_i(1'b1, 32'h0000_0080);
    step();
    idle();
    step();

    // Sustained contention with a data write of the low half-word.
    set_i(1'b1, 32'h0000_0040);
    set_d(1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hCAFE_F00D);
    repeat (4) step();
    idle();
    step();

    // Contention held for three cycles, then the instruction port drops.
    set_i(1'b1, 32'h0001_0020);
    set_d(1'b1, 1'b0, 4'hF, 32'h0001_0040, 32'h0);
    repeat (3) step();
    set_i(1'b0, 32'h0);
    step();
    idle();
    step();

    // Data read just past the 64 KiB window.
    set_d(1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
    step();
    idle();
    step();

    // Back-to-back fetches.
    for (int i = 0; i < 3; i++) begin
      set_i(1'b1, 32'(i * 4));
      step();
    end
    idle();
    step();

    // Reset while a fetch response is outstanding, then contend again.
    set_i(1'b1, 32'h0000_0200);
    step();
    do_reset();
    step();
    set_i(1'b1, 32'h0000_0300);
    set_d(1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'h0);
    step();
    idle();
    step();

    repeat (400) rand_cycle();
    idle();
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
